// File: rtl/fir_seq_ctrl.sv
// Cycle sequencer for the reconfigurable FIR filter: turns the 600 kHz sample strobe into
// RAM read / MAC bursts and replays host-loaded coefficient sets as gap-free write bursts.
module fir_seq_ctrl #(
  parameter int NUM_TAPS = 10,
  parameter int TAIL_CYC = 9,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 8
) (
  input  logic              iClk12M,
  input  logic              iRsn,
  input  logic              iEnSample600k,
  input  logic [2:0]        iSampleIn,
  input  logic [1:0]        iModeSel,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeffData,
  input  logic [1:0]        iCoeffSel,
  output logic              oCoeffReady,
  output logic              oCoeffUpdateFlag,
  output logic [DATA_W-1:0] oWtDtRam,
  output logic              oMemRdFlag,
  output logic [2:0]        oFirIn,
  output logic [1:0]        oModuleSel,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic              oEnMAC,
  output logic              oBusy,
  output logic [CNT_W-1:0]  oDropCnt
);

  localparam int BEAT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int TAIL_W = (TAIL_CYC > 1) ? $clog2(TAIL_CYC) : 1;
  localparam int FILL_W = $clog2(NUM_TAPS + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NUM_TAPS - 1);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_CYC - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM_TAPS);

  typedef enum logic [1:0] {IDLE, WBURST, RBURST, TAIL} state_t;

  state_t             state;
  logic [BEAT_W-1:0]  beat;
  logic [TAIL_W-1:0]  tail_cnt;
  logic [FILL_W-1:0]  fill_cnt;
  logic [FILL_W-1:0]  fill_next;
  logic [1:0]         coeff_sel;
  logic [DATA_W-1:0]  coeff_buf [NUM_TAPS];
  logic               accept;
  logic               wburst_start;
  logic               wburst_last;
  logic               in_wburst_next;
  logic [BEAT_W-1:0]  rd_idx;

  assign accept         = iCoeffValid & oCoeffReady;
  assign wburst_start   = (state == IDLE) && !iEnSample600k && (fill_cnt == FILL_FULL);
  assign wburst_last    = (state == WBURST) && (beat == BEAT_LAST);
  assign in_wburst_next = wburst_start || ((state == WBURST) && !wburst_last);
  assign rd_idx         = wburst_start ? '0 : beat + 1'b1;
  assign fill_next      = wburst_last ? '0 : (accept ? fill_cnt + 1'b1 : fill_cnt);

  // Coefficient staging buffer; no reset so it maps onto plain RAM.
  always_ff @(posedge iClk12M) begin
    if (accept) coeff_buf[fill_cnt[BEAT_W-1:0]] <= iCoeffData;
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state            <= IDLE;
      beat             <= '0;
      tail_cnt         <= '0;
      fill_cnt         <= '0;
      coeff_sel        <= '0;
      oCoeffReady      <= 1'b1;
      oCoeffUpdateFlag <= 1'b0;
      oWtDtRam         <= '0;
      oMemRdFlag       <= 1'b0;
      oFirIn           <= '0;
      oModuleSel       <= '0;
      oCsnRam          <= 1'b1;
      oWrnRam          <= 1'b1;
      oEnMAC           <= 1'b0;
      oBusy            <= 1'b0;
      oDropCnt         <= '0;
    end else begin
      fill_cnt    <= fill_next;
      // Ready looks one cycle ahead so it never admits a word while a write burst is replaying.
      oCoeffReady <= (fill_next < FILL_FULL) && !in_wburst_next;
      if (accept && (fill_cnt == '0)) coeff_sel <= iCoeffSel;
      if (iEnSample600k && (state != IDLE) && (oDropCnt != '1)) oDropCnt <= oDropCnt + 1'b1;

      case (state)
        IDLE: begin
          if (iEnSample600k) begin
            state      <= RBURST;
            beat       <= '0;
            oMemRdFlag <= 1'b1;
            oCsnRam    <= 1'b0;
            oEnMAC     <= 1'b1;
            oModuleSel <= iModeSel;
            oFirIn     <= iSampleIn;
            oBusy      <= 1'b1;
          end else if (fill_cnt == FILL_FULL) begin
            state            <= WBURST;
            beat             <= '0;
            oCoeffUpdateFlag <= 1'b1;
            oCsnRam          <= 1'b0;
            oWrnRam          <= 1'b0;
            oWtDtRam         <= coeff_buf[rd_idx];
            oModuleSel       <= coeff_sel;
            oBusy            <= 1'b1;
          end
        end
        RBURST: begin
          oFirIn <= '0;
          if (beat == BEAT_LAST) begin
            state      <= TAIL;
            tail_cnt   <= '0;
            oMemRdFlag <= 1'b0;
            oCsnRam    <= 1'b1;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        TAIL: begin
          if (tail_cnt == TAIL_LAST) begin
            state  <= IDLE;
            oEnMAC <= 1'b0;
            oBusy  <= 1'b0;
          end else begin
            tail_cnt <= tail_cnt + 1'b1;
          end
        end
        WBURST: begin
          if (beat == BEAT_LAST) begin
            state            <= IDLE;
            oCoeffUpdateFlag <= 1'b0;
            oCsnRam          <= 1'b1;
            oWrnRam          <= 1'b1;
            oWtDtRam         <= '0;
            oBusy            <= 1'b0;
          end else begin
            beat     <= beat + 1'b1;
            oWtDtRam <= coeff_buf[rd_idx];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: read/write burst timing, arbitration, fill port and drop counter.
module tb_fir_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        strobe;
  logic [2:0]  sample;
  logic [1:0]  mode;
  logic        coeff_valid;
  logic [15:0] coeff_data;
  logic [1:0]  coeff_sel;
  logic        coeff_ready;
  logic        update_flag;
  logic [15:0] wt_dt;
  logic        mem_rd;
  logic [2:0]  fir_in;
  logic [1:0]  module_sel;
  logic        csn_ram;
  logic        wrn_ram;
  logic        en_mac;
  logic        busy;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fir_seq_ctrl dut (
    .iClk12M          (clk),
    .iRsn             (rst_n),
    .iEnSample600k    (strobe),
    .iSampleIn        (sample),
    .iModeSel         (mode),
    .iCoeffValid      (coeff_valid),
    .iCoeffData       (coeff_data),
    .iCoeffSel        (coeff_sel),
    .oCoeffReady      (coeff_ready),
    .oCoeffUpdateFlag (update_flag),
    .oWtDtRam         (wt_dt),
    .oMemRdFlag       (mem_rd),
    .oFirIn           (fir_in),
    .oModuleSel       (module_sel),
    .oCsnRam          (csn_ram),
    .oWrnRam          (wrn_ram),
    .oEnMAC           (en_mac),
    .oBusy            (busy),
    .oDropCnt         (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(coeff_ready), 32'd1);
    check({tag, "_upd"},   32'(update_flag), 32'd0);
    check({tag, "_wt"},    32'(wt_dt),       32'd0);
    check({tag, "_rd"},    32'(mem_rd),      32'd0);
    check({tag, "_firin"}, 32'(fir_in),      32'd0);
    check({tag, "_msel"},  32'(module_sel),  32'd0);
    check({tag, "_csn"},   32'(csn_ram),     32'd1);
    check({tag, "_wrn"},   32'(wrn_ram),     32'd1);
    check({tag, "_mac"},   32'(en_mac),      32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_drop"},  32'(drop_cnt),    32'd0);
  endtask

  // Caller raises strobe before the call. Optionally toggles the fill port on even edges.
  task automatic run_rburst(input string tag, input logic [2:0] smp, input logic [1:0] md,
                            input bit toggle_fill, input logic [15:0] base);
    int nacc = 0;
    for (int k = 0; k < 20; k++) begin
      if (toggle_fill) begin
        coeff_valid = (k % 2 == 0);
        coeff_data  = base + 16'(nacc);
        if (coeff_valid) check({tag, "_fill_ready"}, 32'(coeff_ready), 32'd1);
      end
      tick();
      if (toggle_fill && coeff_valid) nacc++;
      strobe = 1'b0;
      if (k < 10) begin
        check({tag, "_rd"},    32'(mem_rd),     32'd1);
        check({tag, "_csn"},   32'(csn_ram),    32'd0);
        check({tag, "_mac"},   32'(en_mac),     32'd1);
        check({tag, "_msel"},  32'(module_sel), 32'(md));
        check({tag, "_firin"}, 32'(fir_in),     (k == 0) ? 32'(smp) : 32'd0);
      end else if (k < 19) begin
        check({tag, "_tail_rd"},  32'(mem_rd),  32'd0);
        check({tag, "_tail_mac"}, 32'(en_mac),  32'd1);
        check({tag, "_tail_csn"}, 32'(csn_ram), 32'd1);
        check({tag, "_tail_busy"}, 32'(busy),   32'd1);
      end else begin
        check({tag, "_idle_busy"}, 32'(busy),   32'd0);
        check({tag, "_idle_mac"},  32'(en_mac), 32'd0);
      end
      check({tag, "_upd"}, 32'(update_flag), 32'd0);
    end
    coeff_valid = 1'b0;
    $display("txn rburst %s sample=%0d mode=%0d words=%0d drop=%0d", tag, smp, md, nacc, drop_cnt);
  endtask

  task automatic load_words(input string tag, input logic [15:0] base, input logic [1:0] sel);
    for (int i = 0; i < 10; i++) begin
      check({tag, "_ready"}, 32'(coeff_ready), 32'd1);
      coeff_valid = 1'b1;
      coeff_data  = base + 16'(i);
      coeff_sel   = (i == 0) ? sel : ~sel;
      tick();
    end
    coeff_valid = 1'b0;
    check({tag, "_full_ready"}, 32'(coeff_ready), 32'd0);
    $display("txn load %s base=0x%0h sel=%0d", tag, base, sel);
  endtask

  // Starts at an IDLE cycle with the buffer full; strobe_beat >= 0 injects a strobe at that beat.
  task automatic run_wburst(input string tag, input logic [15:0] base, input logic [1:0] sel,
                            input int strobe_beat);
    for (int i = 0; i < 10; i++) begin
      tick();
      strobe = 1'b0;
      check({tag, "_upd"},  32'(update_flag), 32'd1);
      check({tag, "_wt"},   32'(wt_dt),       32'(base + 16'(i)));
      check({tag, "_msel"}, 32'(module_sel),  32'(sel));
      check({tag, "_wrn"},  32'(wrn_ram),     32'd0);
      check({tag, "_csn"},  32'(csn_ram),     32'd0);
      check({tag, "_rd"},   32'(mem_rd),      32'd0);
      check({tag, "_ready"}, 32'(coeff_ready), 32'd0);
      if (i == strobe_beat) strobe = 1'b1;
    end
    tick();
    strobe = 1'b0;
    check({tag, "_end_upd"},   32'(update_flag), 32'd0);
    check({tag, "_end_wt"},    32'(wt_dt),       32'd0);
    check({tag, "_end_wrn"},   32'(wrn_ram),     32'd1);
    check({tag, "_end_csn"},   32'(csn_ram),     32'd1);
    check({tag, "_end_busy"},  32'(busy),        32'd0);
    check({tag, "_end_ready"}, 32'(coeff_ready), 32'd1);
    check({tag, "_end_msel"},  32'(module_sel),  32'(sel));
    $display("txn wburst %s base=0x%0h sel=%0d drop=%0d", tag, base, sel, drop_cnt);
  endtask

  initial begin
    rst_n       = 1'b0;
    strobe      = 1'b0;
    sample      = 3'd0;
    mode        = 2'd0;
    coeff_valid = 1'b0;
    coeff_data  = 16'd0;
    coeff_sel   = 2'd0;
    tick();
    tick();
    check_reset_values("por");
    rst_n = 1'b1;
    tick();

    // Read burst, then a second strobe exactly 20 cycles later must not count as a drop
    strobe = 1'b1; sample = 3'b111; mode = 2'd1;
    run_rburst("rb1", 3'b111, 2'd1, 1'b0, 16'h0);
    strobe = 1'b1; sample = 3'b010; mode = 2'd3;
    run_rburst("rb2", 3'b010, 2'd3, 1'b0, 16'h0);
    check("rb2_drop", 32'(drop_cnt), 32'd0);
    check("rb2_msel_hold", 32'(module_sel), 32'd3);

    // Coefficient load and replay
    load_words("ld1", 16'h0A00, 2'd2);
    run_wburst("wb1", 16'h0A00, 2'd2, -1);

    // Strobe during write beat 4: burst unbroken, one drop, no read burst afterwards
    load_words("ld2", 16'h0B00, 2'd1);
    run_wburst("wb2", 16'h0B00, 2'd1, 4);
    check("wb2_drop", 32'(drop_cnt), 32'd1);
    tick();
    check("wb2_no_rd", 32'(mem_rd), 32'd0);
    check("wb2_no_busy", 32'(busy), 32'd0);

    // Buffer full and strobe in the same IDLE cycle: read first, write after tail
    load_words("ld3", 16'h0C00, 2'd3);
    strobe = 1'b1; sample = 3'b101; mode = 2'd0;
    run_rburst("rb3", 3'b101, 2'd0, 1'b0, 16'h0);
    run_wburst("wb3", 16'h0C00, 2'd3, -1);

    // Valid toggled during a read burst fills the buffer (sel latched from the first word)
    coeff_sel = 2'd0;
    strobe = 1'b1; sample = 3'b011; mode = 2'd2;
    run_rburst("rb4", 3'b011, 2'd2, 1'b1, 16'h0D00);
    check("rb4_full_ready", 32'(coeff_ready), 32'd0);
    run_wburst("wb4", 16'h0D00, 2'd0, -1);
    check("wb4_drop", 32'(drop_cnt), 32'd1);

    // Strobe held high: 19 drops per 20-cycle burst, then saturation
    strobe = 1'b1; sample = 3'b001; mode = 2'd1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_first", 32'(drop_cnt), 32'd20);
    for (int i = 0; i < 300; i++) tick();
    check("sat_cap", 32'(drop_cnt), 32'd255);
    strobe = 1'b0;
    begin
      int budget = 0;
      while (busy && budget < 40) begin
        tick();
        budget++;
      end
      check("sat_idle", 32'(busy), 32'd0);
    end
    $display("txn drops saturated drop=%0d", drop_cnt);

    // Asynchronous reset mid read burst
    strobe = 1'b1; sample = 3'b110; mode = 2'd3;
    tick();
    strobe = 1'b0;
    tick();
    tick();
    check("pre_rst_rd", 32'(mem_rd), 32'd1);
    rst_n = 1'b0;
    #2;
    check_reset_values("arst");
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_ready", 32'(coeff_ready), 32'd1);
    $display("txn async reset mid-burst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
